// File: rtl/axi_mm_to_axis_burst_if.sv
// rtl/axi_mm_to_axis_burst_if.sv - AXI4 read-address/read-data and AXI-Stream bundle for the burst reader
//
// master modport: the burst reader side (drives AR, RREADY and the stream).
// slave modport : the memory/stream sink side.
// Signals: m_axi_ar{addr,len,size,burst,prot,valid,ready}, m_axi_r{data,resp,last,valid,ready},
//          m_axis_t{data,last,valid,ready}.

interface axi_mm_to_axis_burst_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;
  logic [AXI_DATA_WIDTH-1:0] m_axis_tdata;
  logic                      m_axis_tlast;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_mm_to_axis_burst.sv
// rtl/axi_mm_to_axis_burst.sv - AXI4 burst reader streaming a contiguous block as one AXI-Stream packet
//
// Ports: ACLK/ARESETn (async active-low), BASE_ADDR/XFER_BEATS/START request, BUSY/DONE/ERROR status,
//        bus (axi_mm_to_axis_burst_if.master): AR and R channels plus the output stream.
// Optional macro AXI_MM2S_RRESP_CHECK_EN: non-OKAY rresp sets sticky ERROR and truncates the packet
// after the current burst. Without it rresp is ignored and ERROR stays 0.

module axi_mm_to_axis_burst #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 16,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [31:0]               XFER_BEATS,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERROR,
  axi_mm_to_axis_burst_if.master    bus
);
  localparam int BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DRAIN, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] addr_q, araddr_q;
  logic [31:0]               remaining_q, total_q, out_cnt_q;
  logic [8:0]                burst_q, beat_cnt_q;
  logic [7:0]                arlen_q;
  logic                      err_q;
  logic [AW:0]               wr_ptr, rd_ptr, count;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [12:0] room_bytes, room_beats;
  logic [31:0] burst_c, free_c;
  logic        space_ok, ar_hs, wr_en, rd_en, last_beat, beat_err, drain_done, trunc_last;

  assign count = wr_ptr - rd_ptr;
  assign ar_hs = bus.m_axi_arvalid & bus.m_axi_arready;
  assign wr_en = bus.m_axi_rvalid & bus.m_axi_rready;
  assign rd_en = bus.m_axis_tvalid & bus.m_axis_tready;
  assign last_beat = wr_en && (beat_cnt_q == burst_q - 9'd1);

`ifdef AXI_MM2S_RRESP_CHECK_EN
  assign beat_err = wr_en && (bus.m_axi_rresp != 2'b00);
`else
  assign beat_err = 1'b0;
`endif

  // Burst size: limited by what is left, the AXI max, and the distance to the next 4 KB page.
  // Only one burst is ever outstanding, so nothing is reserved while in CALC and the plain
  // free count is the space available for the next burst.
  always_comb begin
    room_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
    room_beats = room_bytes >> BSHIFT;
    burst_c    = remaining_q;
    if (burst_c > 32'(MAX_BURST_LEN)) burst_c = 32'(MAX_BURST_LEN);
    if (burst_c > {19'd0, room_beats}) burst_c = {19'd0, room_beats};
    free_c     = 32'(FIFO_DEPTH) - 32'(count);
    space_ok   = free_c >= burst_c;
  end

  // The tlast pop leaves DRAIN in the same edge, so DONE follows the handshake by one cycle.
  assign drain_done = (count == '0) || ((count == (AW+1)'(1)) && rd_en);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = (XFER_BEATS == 32'd0) ? S_FINISH : S_CALC;
      S_CALC:   if (space_ok) state_nxt = S_ADDR;
      S_ADDR:   if (ar_hs) state_nxt = S_DATA;
      S_DATA:   if (last_beat) state_nxt = (remaining_q == 32'd0 || err_q || beat_err) ? S_DRAIN : S_CALC;
      S_DRAIN:  if (drain_done) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY              = (state != S_IDLE);
    DONE              = (state == S_FINISH);
    bus.m_axi_arvalid = (state == S_ADDR);
    bus.m_axi_rready  = (state == S_DATA);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      out_cnt_q   <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (state == S_IDLE && START) begin
        addr_q      <= BASE_ADDR & ~AXI_ADDR_WIDTH'(BYTES - 1);
        remaining_q <= XFER_BEATS;
        total_q     <= XFER_BEATS;
        out_cnt_q   <= '0;
        err_q       <= 1'b0;
      end
      if (state == S_CALC && space_ok) begin
        araddr_q <= addr_q;
        arlen_q  <= burst_c[7:0] - 8'd1;
        burst_q  <= burst_c[8:0];
      end
      if (ar_hs) begin
        addr_q      <= addr_q + (AXI_ADDR_WIDTH'(burst_q) << BSHIFT);
        remaining_q <= remaining_q - 32'(burst_q);
        beat_cnt_q  <= '0;
      end
      if (wr_en) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_cnt_q <= out_cnt_q + 32'd1;
      end
      if (beat_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.m_axi_rdata;
  end

  // After an error the packet ends on whatever is left once the last burst has landed.
  assign trunc_last = err_q && (state == S_DRAIN) && (count == (AW+1)'(1));

  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(BSHIFT);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axis_tvalid = (count != '0);
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? mem[rd_ptr[AW-1:0]] : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && ((out_cnt_q == total_q - 32'd1) || trunc_last);
  assign ERROR             = err_q;

  logic unused_sink;
  assign unused_sink = &{1'b0, bus.m_axi_rlast, bus.m_axi_rresp, burst_c[31:9]};
endmodule

// File: doc/axi_mm_to_axis_burst.md
Name: axi_mm_to_axis_burst

Overview:
AXI4 memory-mapped burst reader that fetches a contiguous block of XFER_BEATS words starting at BASE_ADDR and emits them as one AXI-Stream packet.
- Companion of the stream-to-memory burst writer; feeds video/test pipelines from DDR.
- Splits the transfer into INCR bursts that respect MAX_BURST_LEN and 4 KB boundaries.
- Buffers read data in an internal FIFO and issues a burst only when the FIFO has room for the whole burst, so RREADY never throttles the interconnect.

Parameters:
AXI_DATA_WIDTH, 32, MM and AXIS data width in bits (8..512, power of 2); BYTES = AXI_DATA_WIDTH/8
AXI_ADDR_WIDTH, 32, MM address width
MAX_BURST_LEN, 16, maximum beats per burst (1..256, power of 2)
FIFO_DEPTH, 32, read-data FIFO entries (power of 2, >= MAX_BURST_LEN)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
BASE_ADDR  in  AXI_ADDR_WIDTH  start byte address; low log2(BYTES) bits forced to 0
XFER_BEATS  in  32  total beats to read
START  in  1  start request, sampled in IDLE only
BUSY  out  1  transfer in progress
DONE  out  1  one-cycle completion pulse
ERROR  out  1  sticky read-error flag (see Optional Feature)
m_axi_araddr  out  AXI_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(BYTES), constant
m_axi_arburst  out  2  2'b01 INCR, constant
m_axi_arprot  out  3  3'b000, constant
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  AXI_DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  data valid
m_axi_rready  out  1  data ready
m_axis_tdata  out  AXI_DATA_WIDTH  stream data
m_axis_tlast  out  1  final beat of the transfer
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (ARESETn low, asynchronous): state IDLE, FIFO flushed. All outputs 0 except arsize/arburst constants. Reset mid-burst abandons the transfer; outstanding R beats are not drained (the system resets the interconnect together with this block).
- States:
  - IDLE: BUSY=0. When START=1, latch address and XFER_BEATS, set BUSY=1 next cycle.
    - XFER_BEATS=0 -> FINISH.
    - Otherwise -> CALC.
  - CALC: burst = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0])/BYTES). Wait until FIFO free entries minus reserved entries >= burst, then drive araddr/arlen=burst-1, arvalid=1 -> ADDR.
  - ADDR: hold all AR signals stable until arready. On handshake: reserve burst entries, addr += burst*BYTES, remaining -= burst -> DATA.
  - DATA: m_axi_rready=1. Each rvalid beat is written to the FIFO.
    - On the counted final beat of the burst: remaining>0 -> CALC; remaining=0 -> DRAIN.
    - rlast is ignored for control; the internal beat counter governs.
  - DRAIN: wait until the FIFO is empty and the last stream beat has been accepted -> FINISH.
  - FINISH: DONE=1 for one cycle, BUSY=0 next cycle -> IDLE.
- Only one burst outstanding at a time. START during BUSY is ignored.
- Stream output:
  - tvalid = FIFO not empty; data is first-word-fall-through.
  - The beat is popped on tvalid&tready. tvalid/tdata/tlast stay stable while tready=0.
  - tlast=1 only on beat number XFER_BEATS of the transfer (output beat counter).
- Simultaneous FIFO write and read in the same cycle is allowed at any occupancy, including full and empty.
- Latency:
  - arvalid rises 2 cycles after START sampled, given FIFO space.
  - First tvalid 1 cycle after the first rvalid&rready.
  - DONE 1 cycle after the tlast handshake (FINISH entered from DRAIN).
- Width rules:
  - Byte increment computed at AXI_ADDR_WIDTH; address wraps modulo 2^AXI_ADDR_WIDTH.
  - remaining and beat counters are 32 bits.

Optional Feature:
AXI_MM2S_RRESP_CHECK_EN
- Defined:
  - Any beat with rresp != 2'b00 sets ERROR (sticky; cleared on next accepted START).
  - The current burst's data is still accepted and forwarded. No further AR is issued; go to DRAIN, then FINISH (DONE pulses).
  - The stream packet is truncated; tlast is asserted on the last buffered beat.
- Undefined: rresp is ignored, ERROR is tied to 0.

Test Plan:
- BASE_ADDR=0x1000, XFER_BEATS=40, tready=1 -> ARs (0x1000,len15),(0x1040,len15),(0x1080,len7); 40 stream beats with data matching memory; tlast on beat 40 only; single DONE pulse; BUSY low after it.
- BASE_ADDR=0x0FF0, XFER_BEATS=8 -> ARs (0x0FF0,len3),(0x1000,len3); no burst crosses 4 KB.
- XFER_BEATS=100, FIFO_DEPTH=32, tready high 1 cycle in 4, rvalid every cycle -> no AR issued while free<16; rready never low during DATA; no data loss or reordering; tlast on beat 100.
- XFER_BEATS=0 -> no AR; BUSY high 1 cycle; DONE one cycle after START; tvalid never asserted.
- ARESETn pulsed low during second burst of a 64-beat read -> all outputs at reset values immediately; a following START for 16 beats at 0x2000 completes correctly.
- With AXI_MM2S_RRESP_CHECK_EN, rresp=2'b10 on beat 5 of first burst (XFER_BEATS=48) -> ERROR=1; 16 beats streamed, tlast on beat 16; no second AR; DONE pulses; next START clears ERROR.
